axi_rd_n_merger: RTL and testbench

- Parametrised N-to-1 AXI read-channel merger for the axi_noc fabric.
- Merges NPORTS upstream AR/R slave ports onto one downstream master port.
- AR arbitration is round-robin; the upstream port index is prepended to ARID, so R beats route back statelessly and may interleave between ports.
- Outstanding bursts per port are capped at MAXOUT.

---
 rtl/axi_rd_n_merger.sv | 172 +++++++++++++++++
 tb/tb_axi_rd_n_merger.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_n_merger.sv
// axi_rd_n_merger: N-to-1 AXI read merger, round-robin AR with port index prepended to ARID, stateless R routing.
// Optional checker (sticky panic output) enabled by defining AXI_RD_MERGER_CHECK_EN.
module axi_rd_n_merger #(
    parameter int NPORTS = 4,
    parameter int IDWID  = 4,
    parameter int DWID   = 64,
    parameter int EXTRAS = 8,
    parameter int MAXOUT = 8,
    localparam int PW    = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef AXI_RD_MERGER_CHECK_EN
    output logic                     panic,
`endif
    input  logic [NPORTS*IDWID-1:0]  s_arid,
    input  logic [NPORTS*32-1:0]     s_araddr,
    input  logic [NPORTS*8-1:0]      s_arlen,
    input  logic [NPORTS*EXTRAS-1:0] s_arextras,
    input  logic [NPORTS*2-1:0]      s_arburst,
    input  logic [NPORTS-1:0]        s_arvalid,
    output logic [NPORTS-1:0]        s_arready,
    output logic [NPORTS*IDWID-1:0]  s_rid,
    output logic [NPORTS*DWID-1:0]   s_rdata,
    output logic [NPORTS*2-1:0]      s_rresp,
    output logic [NPORTS-1:0]        s_rlast,
    output logic [NPORTS-1:0]        s_rvalid,
    input  logic [NPORTS-1:0]        s_rready,
    output logic [PW+IDWID-1:0]      arid,
    output logic [31:0]              araddr,
    output logic [7:0]               arlen,
    output logic [EXTRAS-1:0]        arextras,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [PW+IDWID-1:0]      rid,
    input  logic [DWID-1:0]          rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready
);
    localparam int FW = 42 + EXTRAS + IDWID;

    logic [FW-1:0]     r_mem [NPORTS][2];
    logic [NPORTS-1:0] r_wp, r_rp;
    logic [1:0]        r_fc  [NPORTS];
    logic [3:0]        r_out [NPORTS];
    logic [PW-1:0]     r_rr, r_gnt;
    logic              r_lock;

    logic [NPORTS-1:0] w_req, w_push, w_pop, w_dec;
    logic [PW-1:0]     w_sel, w_gnt, w_p;
    logic [FW-1:0]     w_head;
    logic [IDWID-1:0]  w_hid;
    logic              w_found, w_ahs;
    int                w_idx;

    always_comb begin
        for (int k = 0; k < NPORTS; k++) begin
            w_req[k]     = r_fc[k] != 2'd0;
            s_arready[k] = r_fc[k] != 2'd2 && r_out[k] < 4'(MAXOUT);
            w_push[k]    = s_arvalid[k] && s_arready[k];
            w_dec[k]     = s_rvalid[k] && s_rlast[k] && s_rready[k];
        end
    end

    // Cyclic search starting at the round-robin pointer.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < NPORTS; i++) begin
            w_idx = (int'(r_rr) + i) % NPORTS;
            if (!w_found && w_req[w_idx]) begin
                w_sel   = PW'(w_idx);
                w_found = 1'b1;
            end
        end
    end

    assign w_gnt   = r_lock ? r_gnt : w_sel;
    assign w_head  = r_mem[w_gnt][r_rp[w_gnt]];
    assign arvalid = |w_req;
    assign {araddr, arlen, arextras, arburst, w_hid} = w_head;
    assign arid    = {w_gnt, w_hid};
    assign w_ahs   = arvalid && arready;
    assign w_p     = rid[PW+IDWID-1:IDWID];

    always_comb begin
        for (int k = 0; k < NPORTS; k++) w_pop[k] = w_ahs && w_gnt == PW'(k);
    end

    // A port index with no matching port leaves rready high so the beat is dropped.
    always_comb begin
        rready   = 1'b1;
        s_rvalid = '0;
        s_rid    = '0;
        s_rdata  = '0;
        s_rresp  = '0;
        s_rlast  = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (w_p == PW'(k)) begin
                s_rvalid[k]                 = rvalid;
                s_rid[k*IDWID +: IDWID]     = rid[IDWID-1:0];
                s_rdata[k*DWID +: DWID]     = rdata;
                s_rresp[k*2 +: 2]           = rresp;
                s_rlast[k]                  = rlast;
                rready                      = s_rready[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NPORTS; k++)
            if (w_push[k])
                r_mem[k][r_wp[k]] <= {s_araddr[k*32 +: 32], s_arlen[k*8 +: 8],
                                      s_arextras[k*EXTRAS +: EXTRAS], s_arburst[k*2 +: 2],
                                      s_arid[k*IDWID +: IDWID]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr   <= '0;
            r_gnt  <= '0;
            r_lock <= 1'b0;
            r_wp   <= '0;
            r_rp   <= '0;
            for (int k = 0; k < NPORTS; k++) begin
                r_fc[k]  <= 2'd0;
                r_out[k] <= 4'd0;
            end
        end else begin
            if (w_ahs) begin
                r_lock <= 1'b0;
                r_rr   <= (int'(w_gnt) == NPORTS - 1) ? '0 : w_gnt + 1'b1;
            end else if (arvalid) begin
                r_lock <= 1'b1;
                r_gnt  <= w_gnt;
            end
            for (int k = 0; k < NPORTS; k++) begin
                if (w_push[k]) r_wp[k] <= ~r_wp[k];
                if (w_pop[k])  r_rp[k] <= ~r_rp[k];
                r_fc[k]  <= r_fc[k] + 2'(w_push[k]) - 2'(w_pop[k]);
                r_out[k] <= (w_push[k] && !w_dec[k]) ? r_out[k] + 4'd1 :
                            (w_dec[k] && !w_push[k] && r_out[k] != 4'd0) ? r_out[k] - 4'd1 : r_out[k];
            end
        end
    end

`ifdef AXI_RD_MERGER_CHECK_EN
    logic [PW+FW-1:0] r_lpay;
    logic             w_bad;

    always_comb begin
        w_bad = rvalid && int'(w_p) >= NPORTS;
        for (int k = 0; k < NPORTS; k++)
            if (rvalid && w_p == PW'(k) && r_out[k] == 4'd0) w_bad = 1'b1;
        if (r_lock && (!arvalid || {w_gnt, w_head} != r_lpay)) w_bad = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            panic  <= 1'b0;
            r_lpay <= '0;
        end else begin
            if (w_bad) panic <= 1'b1;
            if (arvalid && !arready && !r_lock) r_lpay <= {w_gnt, w_head};
        end
    end
`endif
endmodule

// File: tb/tb_axi_rd_n_merger.sv
// tb_axi_rd_n_merger: directed scenarios plus random traffic checked against a queue-based model.
module tb_axi_rd_n_merger;
    localparam int NP = 3, IW = 4, DW = 64, EX = 8, MO = 2, PW = 2;

    logic                clk = 1'b0, rst_n = 1'b0;
    logic [NP*IW-1:0]    s_arid = '0;
    logic [NP*32-1:0]    s_araddr = '0;
    logic [NP*8-1:0]     s_arlen = '0;
    logic [NP*EX-1:0]    s_arextras = '0;
    logic [NP*2-1:0]     s_arburst = '0;
    logic [NP-1:0]       s_arvalid = '0, s_arready, s_rlast, s_rvalid, s_rready = '0;
    logic [NP*IW-1:0]    s_rid;
    logic [NP*DW-1:0]    s_rdata;
    logic [NP*2-1:0]     s_rresp;
    logic [PW+IW-1:0]    arid, rid = '0;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [EX-1:0]       arextras;
    logic [1:0]          arburst, rresp = '0;
    logic                arvalid, arready = 1'b0, rlast = 1'b0, rvalid = 1'b0, rready;
    logic [DW-1:0]       rdata = '0;
`ifdef AXI_RD_MERGER_CHECK_EN
    logic                panic;
`endif

    always #5 clk = ~clk;

    axi_rd_n_merger #(.NPORTS(NP), .IDWID(IW), .DWID(DW), .EXTRAS(EX), .MAXOUT(MO)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef AXI_RD_MERGER_CHECK_EN
        .panic(panic),
`endif
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arextras(s_arextras),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arextras(arextras), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    typedef struct packed {
        logic [31:0]   addr;
        logic [7:0]    len;
        logic [EX-1:0] ex;
        logic [1:0]    burst;
        logic [IW-1:0] id;
    } ar_t;

    ar_t q [NP][$];
    int  outst [NP];
    int  rr, lg;
    bit  lock;
    int  n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < NP; k++) begin
            q[k].delete();
            outst[k] = 0;
        end
        rr = 0; lg = 0; lock = 0;
    endtask

    task automatic idle();
        s_arvalid = '0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; s_rready = '0; rid = '0;
    endtask

    task automatic set_ar(input int k, input logic [IW-1:0] id, input logic [31:0] a);
        s_arvalid[k]            = 1'b1;
        s_arid[k*IW +: IW]      = id;
        s_araddr[k*32 +: 32]    = a;
        s_arlen[k*8 +: 8]       = 8'(k + 1);
        s_arextras[k*EX +: EX]  = a[7:0];
        s_arburst[k*2 +: 2]     = 2'b01;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        mreset();
        repeat (2) @(negedge clk);
        chk("rst_arready", 64'(s_arready), 64'(3'b111));
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        rst_n = 1'b1;
    endtask

    // One clock cycle: compare DUT outputs with the model, then advance the model across the edge.
    task automatic step();
        logic [NP-1:0]    ea, esv, push, dec, erl;
        logic [NP*DW-1:0] erd;
        logic [NP*IW-1:0] erid;
        logic [NP*2-1:0]  erresp;
        bit               av, found, inr, arh;
        int               g, p;
        ar_t              h, e;
        #1;
        av = 0; g = 0; found = 0;
        for (int k = 0; k < NP; k++) begin
            ea[k] = q[k].size() < 2 && outst[k] < MO;
            if (q[k].size() > 0) av = 1;
        end
        if (lock) g = lg;
        else
            for (int i = 0; i < NP; i++)
                if (!found && q[(rr + i) % NP].size() > 0) begin
                    g = (rr + i) % NP;
                    found = 1;
                end
        chk("s_arready", 64'(s_arready), 64'(ea));
        chk("arvalid", 64'(arvalid), 64'(av));
        if (av) begin
            h = q[g][0];
            chk("arid", 64'(arid), 64'((g << IW) | int'(h.id)));
            chk("ar_payload", {14'd0, araddr, arlen, arextras, arburst}, {14'd0, h.addr, h.len, h.ex, h.burst});
        end
        p   = int'(rid[PW+IW-1:IW]);
        inr = p < NP;
        esv = '0; erd = '0; erid = '0; erresp = '0; erl = '0;
        if (inr) begin
            esv[p]              = rvalid;
            erd[p*DW +: DW]     = rdata;
            erid[p*IW +: IW]    = rid[IW-1:0];
            erresp[p*2 +: 2]    = rresp;
            erl[p]              = rlast;
        end
        chk("rready", 64'(rready), 64'(inr ? s_rready[p] : 1'b1));
        chk("s_rvalid", 64'(s_rvalid), 64'(esv));
        chk("s_rid", 64'(s_rid), 64'(erid));
        chk("s_rlast_rresp", 64'({s_rlast, s_rresp}), 64'({erl, erresp}));
        for (int k = 0; k < NP; k++) chk("s_rdata", s_rdata[k*DW +: DW], erd[k*DW +: DW]);
        arh = av && arready;
        for (int k = 0; k < NP; k++) begin
            push[k] = s_arvalid[k] && ea[k];
            dec[k]  = inr && p == k && rvalid && rlast && s_rready[k];
        end
        @(posedge clk);
        if (arh) begin
            void'(q[g].pop_front());
            rr = (g + 1) % NP;
            lock = 0;
        end else if (av) begin
            lock = 1;
            lg = g;
        end
        for (int k = 0; k < NP; k++) begin
            if (push[k]) begin
                e = '{addr: s_araddr[k*32 +: 32], len: s_arlen[k*8 +: 8], ex: s_arextras[k*EX +: EX],
                      burst: s_arburst[k*2 +: 2], id: s_arid[k*IW +: IW]};
                q[k].push_back(e);
            end
            if (push[k] && !dec[k]) outst[k]++;
            else if (dec[k] && !push[k] && outst[k] > 0) outst[k]--;
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // Round-robin sequence with one request per port.
        do_reset();
        for (int k = 0; k < NP; k++) set_ar(k, 4'd3, 32'h1000 * (k + 1));
        arready = 1'b1;
        step();
        s_arvalid = '0;
        for (int k = 0; k < NP; k++) begin
            #1 chk("t1_arid", 64'(arid), 64'((k << 4) | 3));
            step();
        end
        // Lock holds grant even when a higher-priority port arrives.
        do_reset();
        set_ar(1, 4'd7, 32'hAAAA_0001);
        set_ar(2, 4'd9, 32'hBBBB_0002);
        step();
        for (int i = 0; i < 5; i++) begin
            s_arvalid = '0;
            if (i == 1) set_ar(0, 4'd1, 32'hCCCC_0000);
            #1 chk("t2_lock_port", 64'(arid[5:4]), 64'd1);
            chk("t2_lock_addr", 64'(araddr), 64'hAAAA_0001);
            step();
        end
        s_arvalid = '0;
        arready = 1'b1;
        step();
        #1 chk("t2_next_port", 64'(arid[5:4]), 64'd2);
        step(); step();
        // R routing with stalls; outstanding count drops only on the last handshake.
        do_reset();
        arready = 1'b1;
        set_ar(2, 4'd5, 32'h2000);
        step(); step();
        s_arvalid = '0;
        step(); step();
        #1 chk("t3_capped", 64'(s_arready[2]), 64'd0);
        rid = {2'd2, 4'd5};
        rvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_rready = 3'($urandom);
            s_rready[2] = (i != 1);
            rlast = (i == 4);
            rdata = {$urandom, $urandom};
            rresp = 2'($urandom);
            #1 chk("t3_rid", 64'(s_rid[2*IW +: IW]), 64'd5);
            chk("t3_rready", 64'(rready), 64'(s_rready[2]));
            if (i < 4) chk("t3_still_capped", 64'(s_arready[2]), 64'd0);
            step();
        end
        idle();
        #1 chk("t3_released", 64'(s_arready[2]), 64'd1);
        step();
        // Outstanding cap on port 0 and release after one rlast handshake.
        do_reset();
        arready = 1'b1;
        set_ar(0, 4'd2, 32'h3000);
        step(); step();
        s_arvalid = '0;
        #1 chk("t4_cap", 64'(s_arready[0]), 64'd0);
        step();
        rid = {2'd0, 4'd2}; rvalid = 1'b1; rlast = 1'b1; s_rready = 3'b001;
        step();
        idle();
        #1 chk("t4_free", 64'(s_arready[0]), 64'd1);
        step();
        // Simultaneous accept and completion leave the count unchanged.
        do_reset();
        arready = 1'b1;
        set_ar(2, 4'd1, 32'h4000);
        step();
        rid = {2'd2, 4'd1}; rvalid = 1'b1; rlast = 1'b1; s_rready = 3'b100;
        step();
        idle();
        arready = 1'b1;
        #1 chk("t5_cnt1", 64'(s_arready[2]), 64'd1);
        set_ar(2, 4'd1, 32'h4004);
        step();
        s_arvalid = '0;
        #1 chk("t5_cnt2", 64'(s_arready[2]), 64'd0);
        step();
        // Out-of-range port index: beat dropped, rready forced high.
        rid = {2'd3, 4'd3}; rvalid = 1'b1; s_rready = '0; rlast = 1'b1;
        #1 chk("oor_rready", 64'(rready), 64'd1);
        chk("oor_rvalid", 64'(s_rvalid), 64'd0);
        step();
`ifdef AXI_RD_MERGER_CHECK_EN
        chk("oor_panic", 64'(panic), 64'd1);
`endif
        // Asynchronous reset while locked clears everything, including the rr pointer.
        do_reset();
        arready = 1'b1;
        set_ar(1, 4'd0, 32'h5000);
        step();
        s_arvalid = '0;
        step();
        arready = 1'b0;
        set_ar(0, 4'd0, 32'h5100);
        step();
        s_arvalid = '0;
        step();
        #2 rst_n = 1'b0;
        #1 chk("t6_arvalid", 64'(arvalid), 64'd0);
        chk("t6_arready", 64'(s_arready), 64'(3'b111));
        mreset();
        @(negedge clk);
        rst_n = 1'b1;
        arready = 1'b1;
        set_ar(0, 4'd1, 32'h6000);
        set_ar(2, 4'd2, 32'h6200);
        step();
        s_arvalid = '0;
        #1 chk("t6_rr", 64'(arid[5:4]), 64'd0);
        step(); step();
        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 500; c++) begin
            s_arvalid = 3'($urandom);
            for (int k = 0; k < NP; k++) set_ar(k, 4'($urandom), $urandom);
            s_arvalid = s_arvalid & 3'($urandom);
            arready  = ($urandom % 4) != 0;
            rvalid   = 1'($urandom);
            rid      = 6'($urandom);
            rlast    = ($urandom % 3) == 0;
            s_rready = 3'($urandom);
            rdata    = {$urandom, $urandom};
            rresp    = 2'($urandom);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
